tree_out_arbiter: RTL and testbench

Clocked two-input output-port arbiter for the tree NoC router. Each direction's input controller routes a packet to one of two outputs, so two input controllers can compete for the same output port; this block buffers one packet per requester, grants the port round-robin and forwards packets over a valid/ready handshake. One instance sits in front of each router output port.

---
 rtl/tree_out_arbiter.sv | 145 ++++++++++++++
 tb/tb_tree_out_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tree_out_arbiter.sv
// Two-input output-port arbiter for the tree NoC router: one holding buffer per
// requester, round-robin grant into a single output register, valid/ready on both sides.
module tree_out_arbiter #(
    parameter int unsigned WIDTH_packet  = 14,
    parameter int unsigned PRIORITY_INIT = 0,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH_packet-1:0] in0_data,
    input  logic                    in0_valid,
    output logic                    in0_ready,
    input  logic [WIDTH_packet-1:0] in1_data,
    input  logic                    in1_valid,
    output logic                    in1_ready,
    output logic [WIDTH_packet-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    grant_id,
    output logic [CNT_W-1:0]        pkt_cnt0,
    output logic [CNT_W-1:0]        pkt_cnt1,
    output logic                    busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic RR_INIT = (PRIORITY_INIT != 0);

    state_t                  state_q, state_d;
    logic [WIDTH_packet-1:0] buf0_data_q, buf0_data_d;
    logic [WIDTH_packet-1:0] buf1_data_q, buf1_data_d;
    logic                    buf0_v_q, buf0_v_d;
    logic                    buf1_v_q, buf1_v_d;
    logic [WIDTH_packet-1:0] out_data_q, out_data_d;
    logic                    grant_q, grant_d;
    logic                    rr_q, rr_d;
    logic [CNT_W-1:0]        cnt0_q, cnt0_d;
    logic [CNT_W-1:0]        cnt1_q, cnt1_d;

    logic acc0, acc1;
    logic any_v;
    logic sel;
    logic load;

    // Ready depends only on buffer occupancy, so out_ready never reaches it combinationally.
    assign in0_ready = rst_n & ~buf0_v_q;
    assign in1_ready = rst_n & ~buf1_v_q;
    assign acc0      = in0_valid & in0_ready;
    assign acc1      = in1_valid & in1_ready;

    assign any_v = buf0_v_q | buf1_v_q;
    assign sel   = (buf0_v_q & buf1_v_q) ? rr_q : buf1_v_q;

    always_comb begin
        state_d     = state_q;
        buf0_data_d = buf0_data_q;
        buf1_data_d = buf1_data_q;
        buf0_v_d    = buf0_v_q;
        buf1_v_d    = buf1_v_q;
        out_data_d  = out_data_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        cnt0_d      = cnt0_q;
        cnt1_d      = cnt1_q;
        load        = 1'b0;

        if (acc0) begin
            buf0_v_d    = 1'b1;
            buf0_data_d = in0_data;
        end
        if (acc1) begin
            buf1_v_d    = 1'b1;
            buf1_data_d = in1_data;
        end

        unique case (state_q)
            IDLE: begin
                load = any_v;
            end
            SEND: begin
                if (out_ready) begin
                    if (grant_q) begin
                        cnt1_d = cnt1_q + CNT_W'(1);
                    end else begin
                        cnt0_d = cnt0_q + CNT_W'(1);
                    end
                    load = any_v;
                    if (!any_v) begin
                        state_d = IDLE;
                    end
                end
            end
        endcase

        // A drained buffer was full pre-edge, so it cannot also be accepting this edge.
        if (load) begin
            out_data_d = sel ? buf1_data_q : buf0_data_q;
            grant_d    = sel;
            rr_d       = ~sel;
            state_d    = SEND;
            if (sel) begin
                buf1_v_d = 1'b0;
            end else begin
                buf0_v_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            buf0_data_q <= '0;
            buf1_data_q <= '0;
            buf0_v_q    <= 1'b0;
            buf1_v_q    <= 1'b0;
            out_data_q  <= '0;
            grant_q     <= 1'b0;
            rr_q        <= RR_INIT;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
        end else begin
            state_q     <= state_d;
            buf0_data_q <= buf0_data_d;
            buf1_data_q <= buf1_data_d;
            buf0_v_q    <= buf0_v_d;
            buf1_v_q    <= buf1_v_d;
            out_data_q  <= out_data_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = (state_q == SEND);
    assign grant_id  = grant_q;
    assign pkt_cnt0  = cnt0_q;
    assign pkt_cnt1  = cnt1_q;
    assign busy      = buf0_v_q | buf1_v_q | out_valid;

endmodule

// File: tb/tb_tree_out_arbiter.sv
// Bench for tree_out_arbiter: random and directed traffic checked against a
// transaction-level model of buffers, round-robin pointer and delivery counts.
module tb_tree_out_arbiter;

    localparam int W = 14;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  in0_data = '0, in1_data = '0;
    logic          in0_valid = 1'b0, in1_valid = 1'b0;
    logic          in0_ready, in1_ready;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          grant_id;
    logic [CW-1:0] pkt_cnt0, pkt_cnt1;
    logic          busy;

    int errors = 0;
    int checks = 0;

    tree_out_arbiter #(
        .WIDTH_packet (W),
        .PRIORITY_INIT(0),
        .CNT_W        (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in0_data (in0_data),
        .in0_valid(in0_valid),
        .in0_ready(in0_ready),
        .in1_data (in1_data),
        .in1_valid(in1_valid),
        .in1_ready(in1_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .grant_id (grant_id),
        .pkt_cnt0 (pkt_cnt0),
        .pkt_cnt1 (pkt_cnt1),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Model: each input holds at most one waiting packet; the port holds one in flight.
    logic         mb_v[2];
    logic [W-1:0] mb_d[2];
    logic         mo_v;
    logic [W-1:0] mo_d;
    logic         mo_g;
    logic         mrr;
    int unsigned  mcnt[2];

    task automatic model_reset();
        mb_v[0] = 1'b0; mb_v[1] = 1'b0;
        mo_v = 1'b0; mo_d = '0; mo_g = 1'b0;
        mrr = 1'b0;
        mcnt[0] = 0; mcnt[1] = 0;
    endtask

    // One clock: decide everything from pre-edge state, then apply after the edge.
    task automatic tick();
        logic         take[2];
        logic [W-1:0] din[2];
        logic         deliver, load, pick;
        take[0] = in0_valid && !mb_v[0];
        take[1] = in1_valid && !mb_v[1];
        din[0]  = in0_data;
        din[1]  = in1_data;
        deliver = mo_v && out_ready;
        load    = (!mo_v || deliver) && (mb_v[0] || mb_v[1]);
        if (mb_v[0] && mb_v[1]) pick = mrr;
        else                    pick = mb_v[1];
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (deliver) mcnt[mo_g] = mcnt[mo_g] + 1;
        if (load) begin
            mo_d = mb_d[pick];
            mo_g = pick;
            mrr  = !pick;
            mb_v[pick] = 1'b0;
            mo_v = 1'b1;
        end else if (deliver) begin
            mo_v = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            if (take[i]) begin
                mb_v[i] = 1'b1;
                mb_d[i] = din[i];
            end
        end
    endtask

    task automatic do_reset();
        in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in0_valid = 1'b1;
        in0_data = 14'h0155;
        #1;
        model_reset();
        tick();
        tick();
        checks++; if (in0_ready !== 1'b0) begin errors++; $display("FAIL reset_in0_ready got=%b exp=0", in0_ready); end
        checks++; if (in1_ready !== 1'b0) begin errors++; $display("FAIL reset_in1_ready got=%b exp=0", in1_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (pkt_cnt0 !== 4'd0) begin errors++; $display("FAIL reset_pkt_cnt0 got=%0d exp=0", pkt_cnt0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (out_data !== 14'h0 || grant_id !== 1'b0) begin errors++; $display("FAIL reset_out_regs got=%h/%b exp=0000/0", out_data, grant_id); end
        in0_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++; if (in0_ready !== 1'b1) begin errors++; $display("FAIL release_in0_ready got=%b exp=1", in0_ready); end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in0_data  = 14'h0123;
        in0_valid = 1'b1;
        tick();
        in0_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_latency got=%b exp=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 14'h0123 || grant_id !== 1'b0) begin
            errors++; $display("FAIL single_out got=%b/%h/%b exp=1/0123/0", out_valid, out_data, grant_id);
        end
        tick();
        checks++; if (pkt_cnt0 !== 4'd1) begin errors++; $display("FAIL single_cnt0 got=%0d exp=1", pkt_cnt0); end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle got=%b/%b exp=0/0", out_valid, busy); end
    endtask

    task automatic test_contention();
        int diff;
        do_reset();
        out_ready = 1'b1;
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        in0_data = 14'h0100 | W'($urandom_range(0, 255));
        in1_data = 14'h0200 | W'($urandom_range(0, 255));
        tick();
        for (int k = 0; k < 30; k++) begin
            tick();
            in0_data = 14'h0100 | W'($urandom_range(0, 255));
            in1_data = 14'h0200 | W'($urandom_range(0, 255));
            checks++; if (out_valid !== 1'b1 || grant_id !== 1'(k % 2)) begin
                errors++; $display("FAIL contention_grant k=%0d got=%b/%b exp=1/%0d", k, out_valid, grant_id, k % 2);
            end
            checks++; if (out_data !== mo_d) begin errors++; $display("FAIL contention_data k=%0d got=%h exp=%h", k, out_data, mo_d); end
            diff = int'(pkt_cnt0) - int'(pkt_cnt1);
            if (diff < 0) diff = -diff;
            checks++; if (diff > 1 && diff < 15) begin errors++; $display("FAIL contention_balance got=%0d/%0d exp=diff<=1", pkt_cnt0, pkt_cnt1); end
        end
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        logic         held_g;
        out_ready = 1'b0;
        in0_valid = 1'b1; in0_data = 14'h0A11;
        in1_valid = 1'b1; in1_data = 14'h0B22;
        tick();
        in0_data = 14'h0C33;
        in1_data = 14'h0D44;
        tick();
        tick();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        held   = mo_d;
        held_g = mo_g;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== held || grant_id !== held_g) begin
                errors++; $display("FAIL bp_hold k=%0d got=%h/%b exp=%h/%b", k, out_data, grant_id, held, held_g);
            end
            checks++; if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
                errors++; $display("FAIL bp_ready k=%0d got=%b%b exp=00", k, in0_ready, in1_ready);
            end
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (out_valid !== mo_v || (mo_v && (out_data !== mo_d || grant_id !== mo_g))) begin
                errors++; $display("FAIL bp_drain k=%0d got=%b/%h/%b exp=%b/%h/%b", k, out_valid, out_data, grant_id, mo_v, mo_d, mo_g);
            end
        end
        checks++; if (pkt_cnt0 !== CW'(mcnt[0]) || pkt_cnt1 !== CW'(mcnt[1])) begin
            errors++; $display("FAIL bp_counts got=%0d/%0d exp=%0d/%0d", pkt_cnt0, pkt_cnt1, CW'(mcnt[0]), CW'(mcnt[1]));
        end
        tick();
    endtask

    task automatic test_wrap();
        int guard = 0;
        do_reset();
        out_ready = 1'b1;
        in1_valid = 1'b1;
        while (mcnt[1] < 17 && guard < 200) begin
            in1_data = W'($urandom);
            tick();
            guard++;
        end
        in1_valid = 1'b0;
        checks++; if (guard >= 200) begin errors++; $display("FAIL wrap_timeout got=%0d exp=17 deliveries", mcnt[1]); end
        checks++; if (pkt_cnt1 !== 4'd1) begin errors++; $display("FAIL wrap_cnt1 got=%0d exp=1", pkt_cnt1); end
        checks++; if (pkt_cnt0 !== 4'd0) begin errors++; $display("FAIL wrap_cnt0 got=%0d exp=0", pkt_cnt0); end
        tick(); tick(); tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            in0_valid = 1'($urandom);
            in1_valid = 1'($urandom);
            in0_data  = W'($urandom);
            in1_data  = W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            checks++; if (out_valid !== mo_v || (mo_v && (out_data !== mo_d || grant_id !== mo_g))) begin
                errors++; $display("FAIL rand_out k=%0d got=%b/%h/%b exp=%b/%h/%b", k, out_valid, out_data, grant_id, mo_v, mo_d, mo_g);
            end
            checks++; if (in0_ready !== !mb_v[0] || in1_ready !== !mb_v[1]) begin
                errors++; $display("FAIL rand_ready k=%0d got=%b%b exp=%b%b", k, in0_ready, in1_ready, !mb_v[0], !mb_v[1]);
            end
            checks++; if (pkt_cnt0 !== CW'(mcnt[0]) || pkt_cnt1 !== CW'(mcnt[1])) begin
                errors++; $display("FAIL rand_cnt k=%0d got=%0d/%0d exp=%0d/%0d", k, pkt_cnt0, pkt_cnt1, CW'(mcnt[0]), CW'(mcnt[1]));
            end
            checks++; if (busy !== (mb_v[0] | mb_v[1] | mo_v)) begin
                errors++; $display("FAIL rand_busy k=%0d got=%b exp=%b", k, busy, mb_v[0] | mb_v[1] | mo_v);
            end
        end
    endtask

    task automatic test_midreset();
        out_ready = 1'b0;
        in0_valid = 1'b1; in0_data = 14'h0777;
        in1_valid = 1'b1; in1_data = 14'h0888;
        tick(); tick(); tick();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || !mb_v[1]) begin errors++; $display("FAIL midrst_setup got=%b exp=1", out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 14'h0 || grant_id !== 1'b0) begin
            errors++; $display("FAIL midrst_async got=%b/%b/%h/%b exp=0/0/0000/0", out_valid, busy, out_data, grant_id);
        end
        checks++; if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got=%b%b exp=00", in0_ready, in1_ready); end
        model_reset();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_stale k=%0d got=%b/%b exp=0/0", k, out_valid, busy); end
        end
        checks++; if (pkt_cnt0 !== 4'd0 || pkt_cnt1 !== 4'd0) begin errors++; $display("FAIL midrst_cnt got=%0d/%0d exp=0/0", pkt_cnt0, pkt_cnt1); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_wrap();
        test_random();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
